// File: rtl/multicore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicore_pkg
// Description : Shared types for the pipeline hazard scheduler and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package multicore_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MA   = 2'b01,
        FWD_WB   = 2'b10
    } t_fwd_sel;

    typedef enum logic [1:0] {
        HZ_BOOT   = 2'd0,
        HZ_RUN    = 2'd1,
        HZ_DRAIN  = 2'd2,
        HZ_HALTED = 2'd3
    } t_hz_state;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } t_sb_entry;

    // x0 is hardwired, so a write to it never creates a dependency
    function automatic logic sb_match(input t_sb_entry e, input logic [4:0] rs,
                                      input logic uses);
        return e.valid && e.regwrite && (e.rd != 5'd0) && (e.rd == rs) && uses;
    endfunction

    // Returns {hazard, forward select} for one operand, nearest stage first
    function automatic logic [2:0] resolve_operand(input t_sb_entry ex,
                                                   input t_sb_entry ma,
                                                   input t_sb_entry wb,
                                                   input logic [4:0] rs,
                                                   input logic uses);
        if (sb_match(ex, rs, uses))
            return {1'b1, FWD_NONE};
        else if (sb_match(ma, rs, uses))
            return ma.load ? {1'b1, FWD_NONE} : {1'b0, FWD_MA};
        else if (sb_match(wb, rs, uses))
            return {1'b0, FWD_WB};
        else
            return {1'b0, FWD_NONE};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : 3-entry in-flight destination tracker with forward selection.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import multicore_pkg::*;
(
    input  logic       i_aclk,
    input  logic       i_reset,
    input  logic       i_issue,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic [4:0] i_id_rdest,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_id_regwrite,
    input  logic       i_id_load,
    output logic [1:0] o_forward_a,
    output logic [1:0] o_forward_b,
    output logic       o_hazard,
    output logic       o_ex_valid,
    output logic       o_ma_valid
);

    t_sb_entry  r_ex;
    t_sb_entry  r_ma;
    t_sb_entry  r_wb;
    logic [2:0] w_res_a;
    logic [2:0] w_res_b;

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            r_ex <= '0;
            r_ma <= '0;
            r_wb <= '0;
        end else begin
            r_wb <= r_ma;
            r_ma <= r_ex;
            r_ex <= i_issue ? '{valid: 1'b1, rd: i_id_rdest,
                                regwrite: i_id_regwrite, load: i_id_load}
                            : '0;
        end
    end

    assign w_res_a = resolve_operand(r_ex, r_ma, r_wb, i_id_rs1, i_id_uses_rs1);
    assign w_res_b = resolve_operand(r_ex, r_ma, r_wb, i_id_rs2, i_id_uses_rs2);

    // A stalled instruction does not consume operands, so both selects idle
    assign o_hazard    = w_res_a[2] | w_res_b[2];
    assign o_forward_a = o_hazard ? FWD_NONE : w_res_a[1:0];
    assign o_forward_b = o_hazard ? FWD_NONE : w_res_b[1:0];
    assign o_ex_valid  = r_ex.valid;
    assign o_ma_valid  = r_ma.valid;

endmodule
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scheduler
// Description : 5-stage pipeline sequencing: hazards, flushes, boot and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scheduler
    import multicore_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 i_aclk,
    input  logic                 i_reset,
    input  logic                 i_halt_req,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic [4:0]           i_id_rdest,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic                 i_id_regwrite,
    input  logic                 i_id_load,
    input  logic                 i_id_jal,
    input  logic                 i_ex_redirect,
    output logic [1:0]           o_forward_a,
    output logic [1:0]           o_forward_b,
    output logic                 o_if_hold,
    output logic                 o_id_hold,
    output logic                 o_decode_en,
    output logic                 o_ex_bubble,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic [CNT_WIDTH-1:0] o_flush_count
);

    localparam int                   c_boot_w   = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam logic [c_boot_w-1:0]  c_boot_one = 1;
    localparam logic [c_boot_w-1:0]  c_boot_ini = c_boot_w'(BOOT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = 1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

    t_hz_state            r_state;
    t_hz_state            w_next_state;
    logic [c_boot_w-1:0]  r_boot_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;
    logic                 w_hazard;
    logic                 w_ex_valid;
    logic                 w_ma_valid;
    logic                 w_stall_evt;
    logic                 w_flush_evt;

    hazard_scoreboard u_scoreboard (
        .i_aclk        (i_aclk),
        .i_reset       (i_reset),
        .i_issue       (~o_ex_bubble),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_rdest    (i_id_rdest),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_id_regwrite (i_id_regwrite),
        .i_id_load     (i_id_load),
        .o_forward_a   (o_forward_a),
        .o_forward_b   (o_forward_b),
        .o_hazard      (w_hazard),
        .o_ex_valid    (w_ex_valid),
        .o_ma_valid    (w_ma_valid)
    );

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            r_state    <= HZ_BOOT;
            r_boot_cnt <= c_boot_ini;
        end else begin
            r_state <= w_next_state;
            if (r_state == HZ_BOOT && r_boot_cnt != '0)
                r_boot_cnt <= r_boot_cnt - c_boot_one;
        end
    end

    // DRAIN moves to HALTED on the edge that empties the scoreboard, so
    // o_halted coincides with an empty pipeline.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HZ_BOOT:   if (r_boot_cnt <= c_boot_one) w_next_state = HZ_RUN;
            HZ_RUN:    if (i_halt_req) w_next_state = HZ_DRAIN;
            HZ_DRAIN:  if (!i_halt_req) w_next_state = HZ_RUN;
                       else if (!w_ex_valid && !w_ma_valid) w_next_state = HZ_HALTED;
            HZ_HALTED: if (!i_halt_req) w_next_state = HZ_RUN;
            default:   w_next_state = HZ_BOOT;
        endcase
    end

    always_comb begin
        o_if_hold   = 1'b0;
        o_id_hold   = 1'b0;
        o_decode_en = 1'b1;
        o_ex_bubble = 1'b0;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;
        if (i_reset || r_state == HZ_BOOT) begin
            o_decode_en = 1'b0;
            o_ex_bubble = 1'b1;
        end else if (i_ex_redirect) begin
            o_decode_en = 1'b0;
            o_ex_bubble = 1'b1;
            w_flush_evt = 1'b1;
        end else if (r_state == HZ_RUN) begin
            if (w_hazard) begin
                o_if_hold   = 1'b1;
                o_id_hold   = 1'b1;
                o_ex_bubble = 1'b1;
                w_stall_evt = 1'b1;
            end else if (i_id_jal) begin
                o_decode_en = 1'b0;
                w_flush_evt = 1'b1;
            end
        end else begin
            o_if_hold   = 1'b1;
            o_id_hold   = 1'b1;
            o_ex_bubble = 1'b1;
        end
    end

    assign o_halted = !i_reset && (r_state == HZ_HALTED);

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_evt && r_stall_cycles != c_cnt_max)
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            if (w_flush_evt && r_flush_count != c_cnt_max)
                r_flush_count <= r_flush_count + c_cnt_one;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scheduler
// Description : Directed per-cycle vectors plus drain and saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst, halt, redir, jal, load, regw, u1, u2;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] fa, fb;
    logic       ifh, idh, den, bub, hlt;
    logic [2:0] st, fl;
    logic [8:0] act_flg;
    int         checks   = 0;
    int         failures = 0;
    int         exp_st;

    always #5 clk = ~clk;

    hazard_scheduler #(.BOOT_CYCLES(2), .CNT_WIDTH(3)) dut (
        .i_aclk         (clk),
        .i_reset        (rst),
        .i_halt_req     (halt),
        .i_id_rs1       (rs1),
        .i_id_rs2       (rs2),
        .i_id_rdest     (rd),
        .i_id_uses_rs1  (u1),
        .i_id_uses_rs2  (u2),
        .i_id_regwrite  (regw),
        .i_id_load      (load),
        .i_id_jal       (jal),
        .i_ex_redirect  (redir),
        .o_forward_a    (fa),
        .o_forward_b    (fb),
        .o_if_hold      (ifh),
        .o_id_hold      (idh),
        .o_decode_en    (den),
        .o_ex_bubble    (bub),
        .o_halted       (hlt),
        .o_stall_cycles (st),
        .o_flush_count  (fl)
    );

    // flg = {fa, fb, if_hold, id_hold, decode_en, ex_bubble, halted}
    assign act_flg = {fa, fb, ifh, idh, den, bub, hlt};

    // ctl = {reset, halt, redirect, jal, load, regwrite, uses_rs1, uses_rs2}
    typedef struct packed {
        logic [7:0] ctl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [8:0] flg;
        logic [2:0] st;
        logic [2:0] fl;
    } vec_t;

    vec_t vecs [18];

    task automatic drive(input logic [7:0] ctl, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d);
        {rst, halt, redir, jal, load, regw, u1, u2} = ctl;
        rs1 = a;
        rs2 = b;
        rd  = d;
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cumulative counters: ALU-use adds 1 stall, load-use adds 2
        vecs[0]  = '{8'b1000_0000, 5'd0,  5'd0,  5'd0,  9'b00_00_00010, 3'd0, 3'd0};
        vecs[1]  = '{8'b1000_0000, 5'd0,  5'd0,  5'd0,  9'b00_00_00010, 3'd0, 3'd0};
        vecs[2]  = '{8'b1000_0000, 5'd0,  5'd0,  5'd0,  9'b00_00_00010, 3'd0, 3'd0};
        vecs[3]  = '{8'b0000_0000, 5'd0,  5'd0,  5'd0,  9'b00_00_00010, 3'd0, 3'd0};
        vecs[4]  = '{8'b0000_0000, 5'd0,  5'd0,  5'd0,  9'b00_00_00010, 3'd0, 3'd0};
        vecs[5]  = '{8'b0000_0110, 5'd0,  5'd0,  5'd5,  9'b00_00_00100, 3'd0, 3'd0};
        vecs[6]  = '{8'b0000_0111, 5'd5,  5'd5,  5'd6,  9'b00_00_11110, 3'd0, 3'd0};
        vecs[7]  = '{8'b0000_0111, 5'd5,  5'd5,  5'd6,  9'b01_01_00100, 3'd1, 3'd0};
        vecs[8]  = '{8'b0000_1110, 5'd3,  5'd0,  5'd7,  9'b00_00_00100, 3'd1, 3'd0};
        vecs[9]  = '{8'b0000_0111, 5'd7,  5'd0,  5'd8,  9'b00_00_11110, 3'd1, 3'd0};
        vecs[10] = '{8'b0000_0111, 5'd7,  5'd0,  5'd8,  9'b00_00_11110, 3'd2, 3'd0};
        vecs[11] = '{8'b0000_0111, 5'd7,  5'd0,  5'd8,  9'b10_00_00100, 3'd3, 3'd0};
        vecs[12] = '{8'b0001_0100, 5'd0,  5'd0,  5'd1,  9'b00_00_00000, 3'd3, 3'd0};
        vecs[13] = '{8'b0000_0110, 5'd0,  5'd0,  5'd0,  9'b00_00_00100, 3'd3, 3'd1};
        vecs[14] = '{8'b0000_0111, 5'd0,  5'd0,  5'd9,  9'b00_00_00100, 3'd3, 3'd1};
        vecs[15] = '{8'b0000_1110, 5'd0,  5'd0,  5'd10, 9'b00_00_00100, 3'd3, 3'd1};
        vecs[16] = '{8'b0010_0111, 5'd10, 5'd10, 5'd11, 9'b00_00_00010, 3'd3, 3'd1};
        vecs[17] = '{8'b0000_0000, 5'd0,  5'd0,  5'd0,  9'b00_00_00100, 3'd3, 3'd2};

        drive(8'b1000_0000, 5'd0, 5'd0, 5'd0);
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].ctl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d", i), 16'({act_flg, st, fl}),
                  16'({vecs[i].flg, vecs[i].st, vecs[i].fl}));
            tick();
        end

        // Halt with three instructions in flight at DRAIN entry
        drive(8'b0000_0110, 5'd0, 5'd0, 5'd12);
        @(negedge clk);
        check("halt_pre_issue", 16'(act_flg), 16'(9'b00_00_00100));
        tick();
        drive(8'b0100_0110, 5'd0, 5'd0, 5'd13);
        @(negedge clk);
        check("halt_req_issue", 16'(act_flg), 16'(9'b00_00_00100));
        tick();
        for (int d = 1; d <= 3; d++) begin
            drive(8'b0100_0000, 5'd0, 5'd0, 5'd0);
            @(negedge clk);
            check($sformatf("drain%0d", d), 16'(act_flg), 16'(9'b00_00_11110));
            tick();
        end
        @(negedge clk);
        check("halted", 16'(act_flg), 16'(9'b00_00_11111));
        tick();
        drive(8'b0000_0000, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("halted_release_cycle", 16'(act_flg), 16'(9'b00_00_11111));
        tick();
        @(negedge clk);
        check("resume_run", 16'(act_flg), 16'(9'b00_00_00100));
        tick();

        // Repeated load-use stalls drive the 3-bit stall counter into saturation
        exp_st = 3;
        for (int k = 0; k < 3; k++) begin
            drive(8'b0000_1110, 5'd0, 5'd0, 5'd20);
            @(negedge clk);
            check($sformatf("sat%0d_lw", k), 16'(act_flg), 16'(9'b00_00_00100));
            tick();
            drive(8'b0000_0110, 5'd20, 5'd0, 5'd21);
            @(negedge clk);
            check($sformatf("sat%0d_stall1", k), 16'(act_flg), 16'(9'b00_00_11110));
            tick();
            @(negedge clk);
            check($sformatf("sat%0d_stall2", k), 16'(act_flg), 16'(9'b00_00_11110));
            tick();
            exp_st = (exp_st + 2 > 7) ? 7 : exp_st + 2;
            @(negedge clk);
            check($sformatf("sat%0d_issue", k), 16'({act_flg, st}),
                  16'({9'b10_00_00100, 3'(exp_st)}));
            tick();
        end
        drive(8'b0000_0000, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("flush_final", 16'(fl), 16'(3'd2));
        check("stall_final", 16'(st), 16'(3'd7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
